// File: rtl/branch_ctrl_pkg.sv
// Shared branch encodings and controller state type for the branch controller slice.
package branch_ctrl_pkg;

    localparam logic [2:0] BR_JMP = 3'b100;
    localparam logic [2:0] BR_JZ  = 3'b101;
    localparam logic [2:0] BR_JN  = 3'b110;
    localparam logic [2:0] BR_JC  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bc_state_t;

endpackage

// File: rtl/branch_logic.sv
// Combinational branch decision: JMP always, JZ/JN/JC on the matching flag.
import branch_ctrl_pkg::*;

module branch_logic (
    input  logic       valid,
    input  logic [2:0] code,
    input  logic       fz,
    input  logic       fn,
    input  logic       fc,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        if (valid) begin
            case (code)
                BR_JMP:  taken = 1'b1;
                BR_JZ:   taken = fz;
                BR_JN:   taken = fn;
                BR_JC:   taken = fc;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch controller: registered flags, redirect pulse, fixed-length pipeline flush.
import branch_ctrl_pkg::*;

module branch_ctrl #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [2:0]      ex_branch,
    input  logic [PC_W-1:0] ex_target,
    input  logic            flag_we,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic            alu_c,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_c,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     taken_cnt
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);

    bc_state_t       state_q, state_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [15:0]     taken_q, taken_d;
    logic            fz_q, fn_q, fc_q;
    logic            pc_sel_q;
    logic [PC_W-1:0] pc_target_q;
    logic            dec_valid, dec_taken, take, flag_ld;

    branch_logic u_branch_logic (
        .valid (dec_valid),
        .code  (ex_branch),
        .fz    (fz_q),
        .fn    (fn_q),
        .fc    (fc_q),
        .taken (dec_taken)
    );

    always_comb begin
        dec_valid = ex_valid && (state_q == ST_IDLE);
        take      = dec_taken && !stall;
        flag_ld   = flag_we && ex_valid && !stall && (state_q == ST_IDLE);
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        taken_d   = taken_q;
        flush     = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_INIT;
                    if (taken_q != '1) taken_d = taken_q + 16'd1;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                // Shadow instructions are squashed; only an unstalled cycle advances the flush.
                if (!stall) begin
                    if (fcnt_q == 2'd0) state_d = ST_IDLE;
                    else                fcnt_d  = fcnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            taken_q     <= '0;
            fz_q        <= 1'b0;
            fn_q        <= 1'b0;
            fc_q        <= 1'b0;
            pc_sel_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            taken_q  <= taken_d;
            // Redirect pulse clears on the next edge even under stall, so it never repeats.
            pc_sel_q <= take;
            if (take) pc_target_q <= ex_target;
            if (flag_ld) begin
                fz_q <= alu_z;
                fn_q <= alu_n;
                fc_q <= alu_c;
            end
        end
    end

    assign flag_z    = fz_q;
    assign flag_n    = fn_q;
    assign flag_c    = fc_q;
    assign pc_sel    = pc_sel_q;
    assign pc_target = pc_target_q;
    assign taken_cnt = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_branch = 3'b000;
    logic [31:0] ex_target = '0;
    logic        flag_we = 1'b0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0;
    logic        flag_z, flag_n, flag_c, pc_sel, flush, busy;
    logic [31:0] pc_target;
    logic [15:0] taken_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.PC_W(32), .FLUSH_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .ex_branch (ex_branch),
        .ex_target (ex_target),
        .flag_we   (flag_we),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .pc_sel    (pc_sel),
        .pc_target (pc_target),
        .flush     (flush),
        .busy      (busy),
        .taken_cnt (taken_cnt)
    );

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        v;
        logic [2:0]  br;
        logic [31:0] tgt;
        logic        we;
        logic [2:0]  alu;
        logic        e_psel;
        logic [31:0] e_tgt;
        logic        e_fl;
        logic [2:0]  e_flags;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic v, input logic [2:0] br,
                       input logic [31:0] tgt, input logic we, input logic [2:0] alu,
                       input logic ps, input logic [31:0] et, input logic fl,
                       input logic [2:0] ef, input logic [15:0] ec);
        vec_t x;
        x = '{r, s, v, br, tgt, we, alu, ps, et, fl, ef, ec};
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [2:0] br,
                         input logic [31:0] tgt, input logic we, input logic [2:0] alu);
        rst = r; stall = s; ex_valid = v; ex_branch = br; ex_target = tgt;
        flag_we = we; {alu_z, alu_n, alu_c} = alu;
    endtask

    initial begin
        // rst stl v  br      target        we alu      psel tgt           fl flags   cnt
        add(1, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h0,   0, 3'b000, 16'd0); // 0 reset
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h0,   0, 3'b000, 16'd0);
        add(0, 0, 1, 3'b100, 32'h400, 0, 3'b000,  1, 32'h400, 1, 3'b000, 16'd1); // JMP
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h400, 1, 3'b000, 16'd1);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h400, 0, 3'b000, 16'd1);
        add(0, 0, 1, 3'b000, 32'h0,   1, 3'b100,  0, 32'h400, 0, 3'b100, 16'd1); // z=1
        add(0, 0, 1, 3'b101, 32'h500, 0, 3'b000,  1, 32'h500, 1, 3'b100, 16'd2); // JZ taken
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h500, 1, 3'b100, 16'd2);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h500, 0, 3'b100, 16'd2);
        add(0, 0, 1, 3'b000, 32'h0,   1, 3'b000,  0, 32'h500, 0, 3'b000, 16'd2); // z=0
        add(0, 0, 1, 3'b101, 32'h600, 0, 3'b000,  0, 32'h500, 0, 3'b000, 16'd2); // JZ not
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h500, 0, 3'b000, 16'd2);
        add(0, 0, 1, 3'b100, 32'h700, 0, 3'b000,  1, 32'h700, 1, 3'b000, 16'd3); // JMP
        add(0, 0, 1, 3'b111, 32'h800, 1, 3'b001,  0, 32'h700, 1, 3'b000, 16'd3); // shadow JC
        add(0, 0, 1, 3'b111, 32'h800, 1, 3'b001,  0, 32'h700, 0, 3'b000, 16'd3); // shadow JC
        add(0, 0, 1, 3'b111, 32'h880, 1, 3'b001,  0, 32'h700, 0, 3'b001, 16'd3); // no bypass
        add(0, 0, 1, 3'b111, 32'h900, 0, 3'b000,  1, 32'h900, 1, 3'b001, 16'd4); // JC taken
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h900, 1, 3'b001, 16'd4);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h900, 0, 3'b001, 16'd4);
        add(0, 1, 1, 3'b100, 32'hA00, 1, 3'b110,  0, 32'h900, 0, 3'b001, 16'd4); // idle stall
        add(0, 0, 1, 3'b100, 32'hA00, 1, 3'b110,  1, 32'hA00, 1, 3'b110, 16'd5); // re-eval
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hA00, 1, 3'b110, 16'd5);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hA00, 0, 3'b110, 16'd5);
        add(0, 0, 1, 3'b100, 32'hB00, 0, 3'b000,  1, 32'hB00, 1, 3'b110, 16'd6); // JMP
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hB00, 1, 3'b110, 16'd6);
        add(0, 1, 1, 3'b100, 32'hBBB, 0, 3'b000,  0, 32'hB00, 1, 3'b110, 16'd6); // stall x3
        add(0, 1, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hB00, 1, 3'b110, 16'd6);
        add(0, 1, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hB00, 1, 3'b110, 16'd6);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hB00, 0, 3'b110, 16'd6);
        add(0, 0, 1, 3'b100, 32'hC00, 0, 3'b000,  1, 32'hC00, 1, 3'b110, 16'd7); // JMP
        add(0, 1, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hC00, 1, 3'b110, 16'd7); // stall c1
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hC00, 1, 3'b110, 16'd7);
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'hC00, 0, 3'b110, 16'd7);
        add(0, 0, 1, 3'b000, 32'h0,   1, 3'b010,  0, 32'hC00, 0, 3'b010, 16'd7); // n=1
        add(0, 0, 1, 3'b100, 32'hD00, 0, 3'b000,  1, 32'hD00, 1, 3'b010, 16'd8); // JMP
        add(1, 1, 1, 3'b100, 32'hD00, 0, 3'b000,  0, 32'h0,   0, 3'b000, 16'd0); // rst in flush
        add(0, 0, 1, 3'b110, 32'hE00, 0, 3'b000,  0, 32'h0,   0, 3'b000, 16'd0); // JN not
        add(0, 0, 0, 3'b000, 32'h0,   0, 3'b000,  0, 32'h0,   0, 3'b000, 16'd0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].v, vecs[i].br, vecs[i].tgt,
                  vecs[i].we, vecs[i].alu);
            tick();
            check($sformatf("row%0d pc_sel", i),    {31'd0, pc_sel},               {31'd0, vecs[i].e_psel});
            check($sformatf("row%0d pc_target", i), pc_target,                     vecs[i].e_tgt);
            check($sformatf("row%0d flush", i),     {31'd0, flush},                {31'd0, vecs[i].e_fl});
            check($sformatf("row%0d busy", i),      {31'd0, busy},                 {31'd0, vecs[i].e_fl});
            check($sformatf("row%0d flags", i),     {29'd0, flag_z, flag_n, flag_c}, {29'd0, vecs[i].e_flags});
            check($sformatf("row%0d taken_cnt", i), {16'd0, taken_cnt},            {16'd0, vecs[i].e_cnt});
        end

        // Saturation: preload the counter next-state to 0xFFFE, then keep taking JMPs.
        drive(0, 0, 0, 3'b000, 32'h0, 0, 3'b000);
        force dut.taken_d = 16'hFFFE;
        tick();
        release dut.taken_d;
        check("preload", {16'd0, taken_cnt}, 32'h0000FFFE);
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 3'b100, 32'hF00 + 32'(n), 0, 3'b000);
            tick();
            check($sformatf("sat%0d pc_sel", n), {31'd0, pc_sel}, 32'd1);
            check($sformatf("sat%0d taken_cnt", n), {16'd0, taken_cnt}, 32'h0000FFFF);
            drive(0, 0, 0, 3'b000, 32'h0, 0, 3'b000);
            tick();
            tick();
            check($sformatf("sat%0d idle", n), {31'd0, busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
